mine_map_gen: RTL and testbench

Generates the 8×8 Minesweeper board that the sweep block consumes on `map_i`. On a start pulse it places `MINE_NUM` mines at pseudo-random cells, never on the player's safe cell. It then fills every non-mine cell with its neighbour-mine count and holds the finished 256-bit map with a valid flag. It is the writer side of the `map_i` interface: same cell indexing, same nibble encoding.

---
 rtl/mine_map_gen.sv | 133 +++++++++++++
 tb/tb_mine_map_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mine_map_gen.sv
`default_nettype none
// ============================================================================
// Module   : mine_map_gen
// Purpose  : Builds an 8x8 Minesweeper board (mines plus neighbour counts) on request.
// Revision : 1.0
// ============================================================================
module mine_map_gen #(
  parameter int          MAP_WIDTH       = 8,
  parameter int          MAP_HEIGHT      = 8,
  parameter int          MAP_CELL_LENGTH = 4,
  parameter int          MINE_NUM        = 10,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            gen_start_i,
  input  logic [5:0]                                      safe_position_i,
  output logic [MAP_WIDTH*MAP_HEIGHT*MAP_CELL_LENGTH-1:0] map_o,
  output logic                                            map_valid_o,
  output logic                                            busy_o
);

  localparam int                         CELLS   = MAP_WIDTH * MAP_HEIGHT;
  localparam logic [15:0]                C_SEED  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [6:0]                 C_MINES = 7'(MINE_NUM);
  localparam logic [5:0]                 C_LAST  = 6'(CELLS - 1);
  localparam logic [MAP_CELL_LENGTH-1:0] C_MINE  = MAP_CELL_LENGTH'(9);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLACE = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                                    state_q;
  logic [15:0]                               lfsr_q;
  logic [15:0]                               lfsr_d;
  logic [CELLS-1:0]                          bitmap_q;
  logic [5:0]                                idx_q;
  logic [6:0]                                cnt_q;
  logic [5:0]                                safe_q;
  logic [CELLS*MAP_CELL_LENGTH-1:0]          map_q;
  logic                                      valid_q;
  logic                                      busy_q;

  logic [5:0]                                cand;
  logic                                      cand_ok;
  logic [MAP_CELL_LENGTH-1:0]                cell_val;

  // Popcount of the in-bounds 8-neighbourhood; no wrap between row ends.
  function automatic logic [MAP_CELL_LENGTH-1:0] nbr_count(input logic [CELLS-1:0] bm,
                                                           input logic [5:0] idx);
    logic [MAP_CELL_LENGTH-1:0] n;
    int x, y, nx, ny;
    n = '0;
    x = int'(idx) % MAP_WIDTH;
    y = int'(idx) / MAP_WIDTH;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = x + dx;
        ny = y + dy;
        if ((dx != 0 || dy != 0) && nx >= 0 && nx < MAP_WIDTH && ny >= 0 && ny < MAP_HEIGHT)
          n = n + MAP_CELL_LENGTH'(bm[6'(ny * MAP_WIDTH + nx)]);
      end
    end
    return n;
  endfunction

  always_comb begin
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cand     = lfsr_q[5:0];
    cand_ok  = !bitmap_q[cand] && (cand != safe_q);
    cell_val = bitmap_q[idx_q] ? C_MINE : nbr_count(bitmap_q, idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= C_SEED;
      bitmap_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      safe_q   <= '0;
      map_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // Free-running so the start instant adds entropy to placement.
      lfsr_q <= lfsr_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (gen_start_i) begin
            safe_q   <= safe_position_i;
            bitmap_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            map_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_PLACE;
          end
        end
        S_PLACE: begin
          if (MINE_NUM == 0) begin
            state_q <= S_COUNT;
          end else if (cand_ok) begin
            bitmap_q[cand] <= 1'b1;
            cnt_q          <= cnt_q + 7'd1;
            if (cnt_q + 7'd1 == C_MINES)
              state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          map_q[int'(idx_q) * MAP_CELL_LENGTH +: MAP_CELL_LENGTH] <= cell_val;
          idx_q <= idx_q + 6'd1;
          if (idx_q == C_LAST) begin
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign map_o       = map_q;
  assign map_valid_o = valid_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mine_map_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mine_map_gen
// Purpose  : Randomized self-checking bench for mine_map_gen (10, 63 and 0 mines).
// Revision : 1.0
// ============================================================================
module tb_mine_map_gen;

  localparam int MINES [3] = '{10, 63, 0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start [3];
  logic [5:0]   safe  [3];
  logic [255:0] map   [3];
  logic         valid [3];
  logic         busy  [3];
  logic [15:0]  lm;
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  mine_map_gen #(.MINE_NUM(10)) u_dut0 (
    .clk(clk), .rst(rst), .gen_start_i(start[0]), .safe_position_i(safe[0]),
    .map_o(map[0]), .map_valid_o(valid[0]), .busy_o(busy[0]));
  mine_map_gen #(.MINE_NUM(63)) u_dut1 (
    .clk(clk), .rst(rst), .gen_start_i(start[1]), .safe_position_i(safe[1]),
    .map_o(map[1]), .map_valid_o(valid[1]), .busy_o(busy[1]));
  mine_map_gen #(.MINE_NUM(0)) u_dut2 (
    .clk(clk), .rst(rst), .gen_start_i(start[2]), .safe_position_i(safe[2]),
    .map_o(map[2]), .map_valid_o(valid[2]), .busy_o(busy[2]));

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference pseudo-random sequence, shared by all instances (same seed, same reset).
  always @(posedge clk or posedge rst)
    if (rst) lm <= 16'hACE1;
    else     lm <= lfsr_step(lm);

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference board: draw candidates from the sequence, then recount each cell.
  task automatic build(input logic [15:0] l0, input int m, input logic [5:0] sf,
                       output logic [255:0] em, output int place_cycles);
    bit          mine [64];
    logic [15:0] l;
    int          cnt, c, nx, ny;
    for (int i = 0; i < 64; i++) mine[i] = 1'b0;
    l = l0; cnt = 0; place_cycles = 0;
    if (m == 0) place_cycles = 1;
    else while (cnt < m && place_cycles < 100000) begin
      place_cycles++;
      if (!mine[l[5:0]] && l[5:0] != sf) begin
        mine[l[5:0]] = 1'b1;
        cnt++;
      end
      l = lfsr_step(l);
    end
    em = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (mine[y*8 + x]) c = 9;
        else begin
          c = 0;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
              nx = x + dx; ny = y + dy;
              if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8)
                c += int'(mine[ny*8 + nx]);
            end
        end
        em[(y*8 + x)*4 +: 4] = 4'(c);
      end
    end
  endtask

  task automatic gen(input int d, input logic [5:0] sf, input bit poke_mid);
    logic [255:0] em;
    int           pc, lat, lim, poke, n9;
    @(negedge clk);
    safe[d]  = sf;
    start[d] = 1'b1;
    @(posedge clk);
    #1 start[d] = 1'b0;
    chk("busy_after_start", 256'(busy[d]), 256'(1));
    chk("map_cleared", map[d], '0);
    chk("valid_dropped", 256'(valid[d]), 256'(0));
    build(lm, MINES[d], sf, em, pc);
    lim  = pc + 64;
    poke = poke_mid ? lim - 10 : -1;
    lat  = -1;
    for (int k = 1; k <= lim + 50; k++) begin
      if (k == poke) start[d] = 1'b1;
      @(posedge clk);
      #1 start[d] = 1'b0;
      if (valid[d]) begin
        lat = k;
        break;
      end
    end
    chk("latency", 256'(lat), 256'(lim));
    chk("board", map[d], em);
    chk("busy_at_valid", 256'(busy[d]), 256'(0));
    n9 = 0;
    for (int i = 0; i < 64; i++) if (map[d][i*4 +: 4] == 4'd9) n9++;
    chk("mine_count", 256'(n9), 256'(MINES[d]));
    chk("safe_cell_clear", 256'(map[d][int'(sf)*4 +: 4] == 4'd9), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      safe[d]  = 6'd0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("reset_map", map[d], '0);
      chk("reset_valid", 256'(valid[d]), 256'(0));
      chk("reset_busy", 256'(busy[d]), 256'(0));
    end
    @(negedge clk) rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("idle_map", map[d], '0);
      chk("idle_valid", 256'(valid[d]), 256'(0));
      chk("idle_busy", 256'(busy[d]), 256'(0));
    end

    gen(0, 6'd1, 1'b0);
    gen(1, 6'd0, 1'b0);
    chk("dense_cell0", 256'(map[1][3:0]), 256'(3));
    chk("dense_cell7", 256'(map[1][31:28]), 256'(9));
    chk("dense_cell8", 256'(map[1][35:32]), 256'(9));
    gen(2, 6'($urandom_range(0, 63)), 1'b0);
    chk("empty_board", map[2], '0);
    gen(0, 6'($urandom_range(0, 63)), 1'b1);
    gen(0, 6'($urandom_range(0, 63)), 1'b0);
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 15)) @(posedge clk);
      gen(0, 6'($urandom_range(0, 63)), 1'b0);
    end
    gen(1, 6'($urandom_range(0, 63)), 1'b0);

    @(negedge clk);
    safe[0]  = 6'd20;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("busy_mid_place", 256'(busy[0]), 256'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_map", map[0], '0);
    chk("rst_mid_valid", 256'(valid[0]), 256'(0));
    chk("rst_mid_busy", 256'(busy[0]), 256'(0));
    @(negedge clk) rst = 1'b0;
    gen(0, 6'd5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
